simmem_release_scheduler: RTL and testbench



---
 rtl/simmem_pkg.sv | 21 ++
 rtl/simmem_release_scheduler_if.sv | 38 +++
 rtl/simmem_rr_arbiter.sv | 32 +++
 rtl/simmem_release_scheduler.sv | 153 +++++++++++++++
 tb/tb_simmem_release_scheduler.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/simmem_pkg.sv
// Shared constants and types for the simulated-memory write-response release scheduler.
package simmem_pkg;

    localparam int unsigned NumSlots    = 8;
    localparam int unsigned DelayWidth  = 6;
    localparam int unsigned SlotIdWidth = $clog2(NumSlots);
    localparam int unsigned OccWidth    = SlotIdWidth + 1;
    localparam int unsigned StallWidth  = 16;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_COUNTING,
        SLOT_EXPIRED
    } slot_state_e;

    typedef logic [SlotIdWidth-1:0] slot_id_t;
    typedef logic [DelayWidth-1:0]  delay_t;
    typedef logic [NumSlots-1:0]    slot_vec_t;
    typedef logic [OccWidth-1:0]    occ_t;

endpackage

// File: rtl/simmem_release_scheduler_if.sv
// Entry and release handshake bundle between the response bank and the release scheduler.
// stall_cnt_o exists only when SIMMEM_SCHED_STATS_EN is defined.
interface simmem_release_scheduler_if;
    import simmem_pkg::*;

    logic      entry_valid_i;
    logic      entry_ready_o;
    slot_id_t  entry_slot_i;
    delay_t    entry_delay_i;
    logic      release_valid_o;
    logic      release_ready_i;
    slot_id_t  release_slot_o;
    slot_vec_t release_onehot_o;
    slot_vec_t expired_o;
    occ_t      occupancy_o;
`ifdef SIMMEM_SCHED_STATS_EN
    logic [StallWidth-1:0] stall_cnt_o;
`endif

    modport master (
`ifdef SIMMEM_SCHED_STATS_EN
        input  stall_cnt_o,
`endif
        output entry_valid_i, entry_slot_i, entry_delay_i, release_ready_i,
        input  entry_ready_o, release_valid_o, release_slot_o, release_onehot_o,
               expired_o, occupancy_o
    );

    modport slave (
`ifdef SIMMEM_SCHED_STATS_EN
        output stall_cnt_o,
`endif
        input  entry_valid_i, entry_slot_i, entry_delay_i, release_ready_i,
        output entry_ready_o, release_valid_o, release_slot_o, release_onehot_o,
               expired_o, occupancy_o
    );

endinterface

// File: rtl/simmem_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module simmem_rr_arbiter
    import simmem_pkg::*;
(
    input  slot_vec_t req_i,
    input  slot_id_t  ptr_i,
    output slot_vec_t gnt_onehot_c,
    output slot_id_t  gnt_idx_c,
    output logic      gnt_valid_c
);

    int unsigned idx;

    always_comb begin
        gnt_onehot_c = '0;
        gnt_idx_c    = '0;
        gnt_valid_c  = 1'b0;
        idx          = 0;
        for (int unsigned i = 0; i < NumSlots; i++) begin
            idx = 32'(ptr_i) + i;
            if (idx >= NumSlots) begin
                idx = idx - NumSlots;
            end
            if (!gnt_valid_c && req_i[SlotIdWidth'(idx)]) begin
                gnt_valid_c                       = 1'b1;
                gnt_idx_c                         = SlotIdWidth'(idx);
                gnt_onehot_c[SlotIdWidth'(idx)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/simmem_release_scheduler.sv
// Delays buffered write responses per slot, then offers expired slots round-robin.
// Optional stall counter enabled by SIMMEM_SCHED_STATS_EN.
module simmem_release_scheduler
    import simmem_pkg::*;
(
    input logic                       clk_i,
    input logic                       rst_i,
    simmem_release_scheduler_if.slave bus
);

    slot_state_e state_q [NumSlots];
    slot_state_e state_d [NumSlots];
    delay_t      cnt_q   [NumSlots];
    delay_t      cnt_d   [NumSlots];
    slot_id_t    ptr_q, ptr_d;
    logic        lock_q, lock_d;
    slot_id_t    lock_slot_q, lock_slot_d;
    occ_t        occ_q, occ_d;

    slot_vec_t   expired_vec;
    slot_vec_t   arb_onehot;
    slot_id_t    arb_idx;
    logic        arb_valid;
    logic        rel_valid;
    slot_id_t    rel_slot;
    slot_vec_t   rel_onehot;
    logic        accept;
    logic        release_hs;

    always_comb begin
        for (int unsigned i = 0; i < NumSlots; i++) begin
            expired_vec[i] = (state_q[i] == SLOT_EXPIRED);
        end
    end

    simmem_rr_arbiter u_arb (
        .req_i        (expired_vec),
        .ptr_i        (ptr_q),
        .gnt_onehot_c (arb_onehot),
        .gnt_idx_c    (arb_idx),
        .gnt_valid_c  (arb_valid)
    );

    // A live offer is frozen in lock_slot_q until its handshake.
    always_comb begin
        rel_valid  = lock_q | arb_valid;
        rel_slot   = lock_q ? lock_slot_q : arb_idx;
        rel_onehot = arb_onehot;
        if (lock_q) begin
            rel_onehot              = '0;
            rel_onehot[lock_slot_q] = 1'b1;
        end
        accept     = bus.entry_valid_i && (state_q[bus.entry_slot_i] == SLOT_IDLE);
        release_hs = rel_valid && bus.release_ready_i;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lock_d      = lock_q;
        lock_slot_d = lock_slot_q;
        ptr_d       = ptr_q;
        occ_d       = occ_q;

        for (int unsigned i = 0; i < NumSlots; i++) begin
            case (state_q[i])
                SLOT_IDLE: begin
                    if (accept && (bus.entry_slot_i == SlotIdWidth'(i))) begin
                        if (bus.entry_delay_i == '0) begin
                            state_d[i] = SLOT_EXPIRED;
                        end else begin
                            state_d[i] = SLOT_COUNTING;
                            cnt_d[i]   = bus.entry_delay_i;
                        end
                    end
                end
                SLOT_COUNTING: begin
                    cnt_d[i] = cnt_q[i] - delay_t'(1);
                    if (cnt_q[i] == delay_t'(1)) begin
                        state_d[i] = SLOT_EXPIRED;
                    end
                end
                SLOT_EXPIRED: begin
                    if (release_hs && (rel_slot == SlotIdWidth'(i))) begin
                        state_d[i] = SLOT_IDLE;
                    end
                end
                default: state_d[i] = SLOT_IDLE;
            endcase
        end

        if (release_hs) begin
            lock_d = 1'b0;
            ptr_d  = (rel_slot == SlotIdWidth'(NumSlots - 1)) ? '0 : rel_slot + slot_id_t'(1);
        end else if (rel_valid) begin
            lock_d      = 1'b1;
            lock_slot_d = rel_slot;
        end

        case ({accept, release_hs})
            2'b10:   occ_d = occ_q + occ_t'(1);
            2'b01:   occ_d = occ_q - occ_t'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= '{default: SLOT_IDLE};
            cnt_q       <= '{default: '0};
            ptr_q       <= '0;
            lock_q      <= 1'b0;
            lock_slot_q <= '0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            lock_q      <= lock_d;
            lock_slot_q <= lock_slot_d;
            occ_q       <= occ_d;
        end
    end

`ifdef SIMMEM_SCHED_STATS_EN
    logic [StallWidth-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (rel_valid && !bus.release_ready_i && (stall_q != '1)) begin
            stall_d = stall_q + StallWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.stall_cnt_o = stall_q;
`endif

    assign bus.entry_ready_o    = (state_q[bus.entry_slot_i] == SLOT_IDLE);
    assign bus.release_valid_o  = rel_valid;
    assign bus.release_slot_o   = rel_slot;
    assign bus.release_onehot_o = rel_onehot;
    assign bus.expired_o        = expired_vec;
    assign bus.occupancy_o      = occ_q;

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Directed self-checking bench for simmem_release_scheduler (stall checks under SIMMEM_SCHED_STATS_EN).
module tb_simmem_release_scheduler;
    import simmem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    simmem_release_scheduler_if bus ();

    simmem_release_scheduler dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.entry_valid_i   = 1'b0;
        bus.release_ready_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Offers one entry for a cycle and expects it to be taken.
    task automatic accept(input int slot, input int dly);
        bus.entry_valid_i = 1'b1;
        bus.entry_slot_i  = SlotIdWidth'(slot);
        bus.entry_delay_i = DelayWidth'(dly);
        #1;
        check_eq("accept_ready", 32'(bus.entry_ready_o), 1);
        tick();
        bus.entry_valid_i = 1'b0;
    endtask

    initial begin
        int seen;
        bus.entry_valid_i   = 1'b0;
        bus.entry_slot_i    = '0;
        bus.entry_delay_i   = '0;
        bus.release_ready_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check_eq("rst_valid",   32'(bus.release_valid_o), 0);
        check_eq("rst_slot",    32'(bus.release_slot_o), 0);
        check_eq("rst_onehot",  32'(bus.release_onehot_o), 0);
        check_eq("rst_expired", 32'(bus.expired_o), 0);
        check_eq("rst_occ",     32'(bus.occupancy_o), 0);
        check_eq("rst_ready",   32'(bus.entry_ready_o), 1);

        // slot 3, delay 5: offer appears 6 cycles after the accept cycle
        accept(3, 5);
        repeat (4) tick();
        check_eq("d5_early_valid", 32'(bus.release_valid_o), 0);
        check_eq("d5_occ",         32'(bus.occupancy_o), 1);
        tick();
        check_eq("d5_valid",   32'(bus.release_valid_o), 1);
        check_eq("d5_slot",    32'(bus.release_slot_o), 3);
        check_eq("d5_onehot",  32'(bus.release_onehot_o), 32'h08);
        check_eq("d5_expired", 32'(bus.expired_o), 32'h08);
        bus.release_ready_i = 1'b1;
        tick();
        bus.release_ready_i = 1'b0;
        bus.entry_slot_i    = 3'd3;
        #1;
        check_eq("d5_after_valid", 32'(bus.release_valid_o), 0);
        check_eq("d5_after_occ",   32'(bus.occupancy_o), 0);
        check_eq("d5_after_idle",  32'(bus.entry_ready_o), 1);

        // delay 0 expires the next cycle; re-offer of the expired slot is refused
        accept(0, 0);
        check_eq("d0_valid", 32'(bus.release_valid_o), 1);
        check_eq("d0_slot",  32'(bus.release_slot_o), 0);
        bus.entry_valid_i = 1'b1;
        bus.entry_slot_i  = 3'd0;
        #1;
        check_eq("d0_reoffer_ready", 32'(bus.entry_ready_o), 0);
        bus.entry_valid_i   = 1'b0;
        bus.release_ready_i = 1'b1;
        tick();
        bus.release_ready_i = 1'b0;
        check_eq("d0_occ", 32'(bus.occupancy_o), 0);

        // slots 1,5,6 expire together with pointer 0
        do_reset();
        accept(1, 2);
        accept(5, 1);
        accept(6, 0);
        check_eq("rr_expired", 32'(bus.expired_o), 32'h62);
        check_eq("rr_g0", 32'(bus.release_slot_o), 1);
        bus.release_ready_i = 1'b1;
        tick();
        check_eq("rr_g1", 32'(bus.release_slot_o), 5);
        tick();
        check_eq("rr_g2", 32'(bus.release_slot_o), 6);
        check_eq("rr_g2_valid", 32'(bus.release_valid_o), 1);
        tick();
        bus.release_ready_i = 1'b0;
        check_eq("rr_done_valid", 32'(bus.release_valid_o), 0);
        check_eq("rr_done_occ",   32'(bus.occupancy_o), 0);
        // pointer now 7: slots 0 and 7 expiring together grant 7 first
        accept(0, 1);
        accept(7, 0);
        check_eq("ptr7_slot",   32'(bus.release_slot_o), 7);
        check_eq("ptr7_onehot", 32'(bus.release_onehot_o), 32'h80);
        bus.release_ready_i = 1'b1;
        tick();
        check_eq("ptr_wrap_slot", 32'(bus.release_slot_o), 0);
        tick();
        bus.release_ready_i = 1'b0;

        // locked offer of slot 2 survives slot 1 expiring; four stall cycles
        do_reset();
        accept(1, 3);
        accept(2, 0);
        check_eq("lock_s0", 32'(bus.release_slot_o), 2);
        tick();
        check_eq("lock_s1", 32'(bus.release_slot_o), 2);
        tick();
        check_eq("lock_expired", 32'(bus.expired_o), 32'h06);
        check_eq("lock_s2", 32'(bus.release_slot_o), 2);
        tick();
        check_eq("lock_s3",      32'(bus.release_slot_o), 2);
        check_eq("lock_onehot3", 32'(bus.release_onehot_o), 32'h04);
        tick();
        check_eq("lock_s4", 32'(bus.release_slot_o), 2);
`ifdef SIMMEM_SCHED_STATS_EN
        check_eq("stall_cnt", 32'(bus.stall_cnt_o), 4);
`endif
        bus.release_ready_i = 1'b1;
        tick();
        check_eq("lock_next", 32'(bus.release_slot_o), 1);
`ifdef SIMMEM_SCHED_STATS_EN
        check_eq("stall_hold", 32'(bus.stall_cnt_o), 4);
`endif
        tick();
        bus.release_ready_i = 1'b0;
        check_eq("lock_done_valid", 32'(bus.release_valid_o), 0);

        // fill all slots; slot 4 expires immediately
        accept(0, 60);
        accept(1, 60);
        accept(2, 60);
        accept(3, 60);
        accept(5, 60);
        accept(6, 60);
        accept(7, 60);
        accept(4, 0);
        check_eq("full_occ", 32'(bus.occupancy_o), 8);
        for (int i = 0; i < 8; i++) begin
            bus.entry_slot_i = SlotIdWidth'(i);
            #1;
            check_eq($sformatf("full_ready%0d", i), 32'(bus.entry_ready_o), 0);
            tick();
        end
        // release and re-accept of slot 4 in one cycle: accept refused
        bus.entry_valid_i   = 1'b1;
        bus.entry_slot_i    = 3'd4;
        bus.entry_delay_i   = '0;
        bus.release_ready_i = 1'b1;
        #1;
        check_eq("same_slot_ready", 32'(bus.entry_ready_o), 0);
        check_eq("same_slot_rel",   32'(bus.release_slot_o), 4);
        tick();
        bus.entry_valid_i   = 1'b0;
        bus.release_ready_i = 1'b0;
        #1;
        check_eq("same_slot_occ",   32'(bus.occupancy_o), 7);
        check_eq("same_slot_valid", 32'(bus.release_valid_o), 0);
        check_eq("same_slot_idle",  32'(bus.entry_ready_o), 1);

        // reset mid-operation discards everything
        accept(4, 0);
        check_eq("pre_rst_valid", 32'(bus.release_valid_o), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_valid",   32'(bus.release_valid_o), 0);
        check_eq("mid_rst_slot",    32'(bus.release_slot_o), 0);
        check_eq("mid_rst_onehot",  32'(bus.release_onehot_o), 0);
        check_eq("mid_rst_expired", 32'(bus.expired_o), 0);
        check_eq("mid_rst_occ",     32'(bus.occupancy_o), 0);
        seen = 0;
        repeat (70) begin
            tick();
            if (bus.release_valid_o) seen++;
        end
        check_eq("no_ghost_release", 32'(seen), 0);

        // maximum delay counts the full 63 cycles without wrapping
        accept(2, 63);
        repeat (62) tick();
        check_eq("dmax_early", 32'(bus.release_valid_o), 0);
        tick();
        check_eq("dmax_valid", 32'(bus.release_valid_o), 1);
        check_eq("dmax_slot",  32'(bus.release_slot_o), 2);
        bus.release_ready_i = 1'b1;
        tick();
        bus.release_ready_i = 1'b0;
        check_eq("dmax_occ", 32'(bus.occupancy_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
